// File: rtl/lemmings_world.sv
// Terrain model for the Lemmings2 walker FSM. It holds the wall and hole maps,
// tracks the lemming's cell, and returns the bump and ground feedback.
module lemmings_world #(
  parameter int WIDTH     = 16,
  parameter int START_POS = 8,
  parameter int DEPTH     = 3,
  localparam int PW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             terrain_load,
  input  logic [WIDTH-1:0] wall_map,
  input  logic [WIDTH-1:0] hole_map,
  input  logic             walk_left,
  input  logic             walk_right,
  input  logic             aaah,
  output logic             bump_left,
  output logic             bump_right,
  output logic             ground,
  output logic [PW-1:0]    pos,
  output logic             landed,
  output logic             err
);

  localparam logic [PW-1:0]    START      = PW'(START_POS);
  localparam logic [PW-1:0]    LAST       = PW'(WIDTH - 1);
  localparam logic [7:0]       DEPTH_M1   = 8'(DEPTH - 1);
  localparam logic [WIDTH-1:0] SPAWN_MASK = ~(WIDTH'(1) << START_POS);

  logic [WIDTH-1:0] wall_r;
  logic [WIDTH-1:0] hole_r;
  logic [7:0]       fall_cnt;

  // The edge cells act as walls; a wall in the occupied cell is never consulted.
  always_comb begin
    ground     = ~hole_r[pos];
    bump_left  = 1'b1;
    bump_right = 1'b1;
    if (pos != '0)
      bump_left = wall_r[pos - 1'b1];
    if (pos != LAST)
      bump_right = wall_r[pos + 1'b1];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wall_r   <= '0;
      hole_r   <= '0;
      pos      <= START;
      fall_cnt <= '0;
      landed   <= 1'b0;
      err      <= 1'b0;
    end else if (terrain_load) begin
      wall_r   <= wall_map & SPAWN_MASK;
      hole_r   <= hole_map & SPAWN_MASK;
      pos      <= START;
      fall_cnt <= '0;
      landed   <= 1'b0;
    end else if (!ground) begin
      // Walker inputs are ignored while falling; the hole fills after DEPTH cycles.
      if (fall_cnt == DEPTH_M1) begin
        hole_r[pos] <= 1'b0;
        fall_cnt    <= '0;
        landed      <= 1'b1;
      end else begin
        fall_cnt <= fall_cnt + 8'd1;
        landed   <= 1'b0;
      end
    end else begin
      landed <= 1'b0;
      if (walk_left && walk_right) begin
        err <= 1'b1;
      end else if (!aaah) begin
        if (walk_left && !bump_left)
          pos <= pos - 1'b1;
        else if (walk_right && !bump_right)
          pos <= pos + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lemmings_world.sv
// Bench for lemmings_world: a behavioural terrain model predicts the outputs for
// every edge, queues them, and they are compared against the DUT after the edge.
module tb_lemmings_world;

  localparam int WIDTH = 16;
  localparam int START = 8;
  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        terrain_load = 1'b0;
  logic [15:0] wall_map = '0;
  logic [15:0] hole_map = '0;
  logic        walk_left = 1'b0;
  logic        walk_right = 1'b0;
  logic        aaah = 1'b0;
  logic        bump_left, bump_right, ground, landed, err;
  logic [3:0]  pos;

  lemmings_world #(.WIDTH(WIDTH), .START_POS(START), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .terrain_load(terrain_load),
    .wall_map(wall_map), .hole_map(hole_map),
    .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground),
    .pos(pos), .landed(landed), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pos;
    logic       ground;
    logic       bl;
    logic       br;
    logic       landed;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference terrain
  bit m_wall[WIDTH];
  bit m_hole[WIDTH];
  int m_pos = START;
  int m_cnt = 0;
  bit m_landed = 0;
  bit m_err = 0;

  function automatic bit m_ground();
    return !m_hole[m_pos];
  endfunction

  function automatic bit m_bl();
    if (m_pos == 0) return 1'b1;
    return m_wall[m_pos - 1];
  endfunction

  function automatic bit m_br();
    if (m_pos == WIDTH - 1) return 1'b1;
    return m_wall[m_pos + 1];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic model_edge(input bit rn, ld, wl, wr, ah, input logic [15:0] wm, hm);
    bit g, bl, br;
    g = m_ground(); bl = m_bl(); br = m_br();
    if (!rn) begin
      foreach (m_wall[i]) begin m_wall[i] = 0; m_hole[i] = 0; end
      m_pos = START; m_cnt = 0; m_landed = 0; m_err = 0;
    end else if (ld) begin
      foreach (m_wall[i]) begin
        m_wall[i] = (i == START) ? 1'b0 : wm[i];
        m_hole[i] = (i == START) ? 1'b0 : hm[i];
      end
      m_pos = START; m_cnt = 0; m_landed = 0;
    end else if (!g) begin
      if (m_cnt == DEPTH - 1) begin
        m_hole[m_pos] = 0; m_cnt = 0; m_landed = 1;
      end else begin
        m_cnt++; m_landed = 0;
      end
    end else begin
      m_landed = 0;
      if (wl && wr) m_err = 1;
      else if (!ah) begin
        if (wl && !bl) m_pos--;
        else if (wr && !br) m_pos++;
      end
    end
  endtask

  task automatic step(input bit rn, ld, wl, wr, ah,
                      input logic [15:0] wm = 16'h0, input logic [15:0] hm = 16'h0);
    exp_t e, got;
    resetn = rn; terrain_load = ld; walk_left = wl; walk_right = wr; aaah = ah;
    wall_map = wm; hole_map = hm;
    model_edge(rn, ld, wl, wr, ah, wm, hm);
    e.pos = 4'(m_pos); e.ground = m_ground(); e.bl = m_bl(); e.br = m_br();
    e.landed = m_landed; e.err = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_eq("sb_pos", 32'(pos), 32'(got.pos));
    check_eq("sb_ground", 32'(ground), 32'(got.ground));
    check_eq("sb_bump_left", 32'(bump_left), 32'(got.bl));
    check_eq("sb_bump_right", 32'(bump_right), 32'(got.br));
    check_eq("sb_landed", 32'(landed), 32'(got.landed));
    check_eq("sb_err", 32'(err), 32'(got.err));
  endtask

  task automatic idle(input int n = 1);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk); #1;

    // Reset
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 16'hffff, 16'hffff);
    step(1, 0, 0, 0, 0);
    check_eq("rst_pos", 32'(pos), 32'd8);
    check_eq("rst_ground", 32'(ground), 32'd1);
    check_eq("rst_bumps", 32'({bump_left, bump_right}), 32'd0);
    check_eq("rst_landed_err", 32'({landed, err}), 32'd0);

    // Right boundary
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 0, 1, 0);
      check_eq("right_pos", 32'(pos), (8 + i > 15) ? 32'd15 : 32'(8 + i));
      check_eq("right_bump", 32'(bump_right), (8 + i >= 15) ? 32'd1 : 32'd0);
    end

    // Wall at cell 5
    step(1, 1, 0, 0, 0, 16'h0020, 16'h0000);
    check_eq("wall_respawn", 32'(pos), 32'd8);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 1, 0, 0, 16'h0020, 16'h0000);
      check_eq("wall_pos", 32'(pos), (i == 1) ? 32'd7 : 32'd6);
      check_eq("wall_bump_right", 32'(bump_right), 32'd0);
    end
    check_eq("wall_bump_left", 32'(bump_left), 32'd1);

    // Hole at cell 10; walk_right stays high through the fall
    step(1, 1, 0, 0, 0, 16'h0000, 16'h0400);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check_eq("hole_pos", 32'(pos), 32'd10);
    check_eq("hole_fall1", 32'(ground), 32'd0);
    step(1, 0, 0, 1, 0);
    check_eq("hole_fall2", 32'(ground), 32'd0);
    step(1, 0, 0, 1, 0);
    check_eq("hole_fall3", 32'({ground, landed}), 32'd0);
    step(1, 0, 0, 1, 0);
    check_eq("hole_land", 32'({ground, landed}), 32'd3);
    check_eq("hole_land_pos", 32'(pos), 32'd10);
    step(1, 0, 0, 0, 1);
    check_eq("hole_aaah_pos", 32'(pos), 32'd10);
    check_eq("hole_landed_pulse", 32'(landed), 32'd0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    check_eq("hole_filled", 32'({pos, ground}), 32'({4'd10, 1'b1}));

    // Illegal and stale inputs
    step(1, 0, 1, 1, 0);
    check_eq("illegal_err", 32'(err), 32'd1);
    check_eq("illegal_pos", 32'(pos), 32'd10);
    step(1, 0, 0, 1, 1);
    check_eq("aaah_pos", 32'(pos), 32'd10);
    step(1, 1, 0, 0, 0, 16'h0000, 16'h0000);
    check_eq("err_sticky", 32'(err), 32'd1);

    // Reset mid-fall
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 16'h0000, 16'h0400);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    check_eq("midfall_ground", 32'(ground), 32'd0);
    step(0, 0, 0, 0, 1);
    check_eq("midrst_state", 32'({pos, ground, landed, err}), 32'({4'd8, 1'b1, 1'b0, 1'b0}));
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check_eq("midrst_hole_cleared", 32'({pos, ground}), 32'({4'd10, 1'b1}));

    // terrain_load mid-fall, with a hole under the spawn cell that must be ignored
    step(1, 1, 0, 0, 0, 16'h0000, 16'h0500);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 16'h0200, 16'h0100);
    check_eq("midload_state", 32'({pos, ground, bump_right}), 32'({4'd8, 1'b1, 1'b1}));

    // Random soak
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
           16'($urandom & $urandom & $urandom), 16'($urandom & $urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
